// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: datapath width, bubble encoding and fetch FSM states.
package rv_pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of pipeline control, instruction-memory handshake and IF/ID outputs of the fetch stage.
interface fetch_stage_if;
    import rv_pipe_pkg::*;

    logic            STALL;
    logic            BUSY_WAIT;
    logic            BRANCH_TAKEN;
    logic [XLEN-1:0] BRANCH_TARGET;
    logic            IMEM_BUSY_WAIT;
    logic [XLEN-1:0] IMEM_RDATA;
    logic            IMEM_READ;
    logic [XLEN-1:0] IMEM_ADDR;
    logic [XLEN-1:0] INSTR_OUT;
    logic [XLEN-1:0] PC_OUT;
    logic [XLEN-1:0] PC_INCREMENT4_OUT;
    logic            VALID_OUT;

    modport master (
        input  STALL, BUSY_WAIT, BRANCH_TAKEN, BRANCH_TARGET, IMEM_BUSY_WAIT, IMEM_RDATA,
        output IMEM_READ, IMEM_ADDR, INSTR_OUT, PC_OUT, PC_INCREMENT4_OUT, VALID_OUT
    );

    modport slave (
        output STALL, BUSY_WAIT, BRANCH_TAKEN, BRANCH_TARGET, IMEM_BUSY_WAIT, IMEM_RDATA,
        input  IMEM_READ, IMEM_ADDR, INSTR_OUT, PC_OUT, PC_INCREMENT4_OUT, VALID_OUT
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble takes priority over load, otherwise contents hold.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_pc,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        valid
);
    import rv_pipe_pkg::*;

    logic [XLEN-1:0] instr_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_plus4_reg;
    logic            valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_reg    <= NOP_INSTR;
            pc_reg       <= '0;
            pc_plus4_reg <= '0;
            valid_reg    <= 1'b0;
        end else if (bubble) begin
            instr_reg    <= NOP_INSTR;
            pc_reg       <= '0;
            pc_plus4_reg <= '0;
            valid_reg    <= 1'b0;
        end else if (load) begin
            instr_reg    <= d_instr;
            pc_reg       <= d_pc;
            pc_plus4_reg <= d_pc + 32'd4;
            valid_reg    <= 1'b1;
        end
    end

    assign instr    = instr_reg;
    assign pc       = pc_reg;
    assign pc_plus4 = pc_plus4_reg;
    assign valid    = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC generation, busy-wait imem handshake with a one-entry skid buffer,
// redirect draining, and the IF/ID register feeding decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
    input  logic          CLK,
    input  logic          RESET,
    fetch_stage_if.master bus
);
    import rv_pipe_pkg::*;

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] pend_reg, pend_next;
    logic [XLEN-1:0] buf_instr_reg, buf_instr_next;
    logic [XLEN-1:0] buf_pc_reg, buf_pc_next;

    logic            imem_read;
    logic            complete;
    logic            advance;
    logic            redirect;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;
    logic            load_fetch;
    logic            load_buf;
    logic            bubble;
    logic [XLEN-1:0] d_instr;
    logic [XLEN-1:0] d_pc;

    assign imem_read = !RESET && (state_reg != HOLD);
    assign complete  = imem_read && !bus.IMEM_BUSY_WAIT;
    assign advance   = !bus.STALL && !bus.BUSY_WAIT;
    // A flush from EX beats a load-use stall, but not a data-memory wait.
    assign redirect  = bus.BRANCH_TAKEN && !bus.BUSY_WAIT;
    assign target    = bus.BRANCH_TARGET & ~32'd3;
    assign pc_plus4  = pc_reg + 32'd4;

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        pend_next      = pend_reg;
        buf_instr_next = buf_instr_reg;
        buf_pc_next    = buf_pc_reg;
        load_fetch     = 1'b0;
        load_buf       = 1'b0;
        bubble         = 1'b0;
        case (state_reg)
            FETCH: begin
                if (complete) begin
                    if (redirect) begin
                        bubble  = 1'b1;
                        pc_next = target;
                    end else if (advance) begin
                        load_fetch = 1'b1;
                        pc_next    = pc_plus4;
                    end else begin
                        buf_instr_next = bus.IMEM_RDATA;
                        buf_pc_next    = pc_reg;
                        pc_next        = pc_plus4;
                        state_next     = HOLD;
                    end
                end else if (redirect) begin
                    bubble     = 1'b1;
                    pend_next  = target;
                    state_next = DRAIN;
                end else if (advance) begin
                    bubble = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    bubble     = 1'b1;
                    pc_next    = target;
                    state_next = FETCH;
                end else if (advance) begin
                    load_buf   = 1'b1;
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pend_next = target;
                end
                bubble = redirect || advance;
                // The stale response is dropped; the newest redirect address wins.
                if (complete) begin
                    pc_next    = redirect ? target : pend_reg;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg     <= FETCH;
            pc_reg        <= RESET_PC;
            pend_reg      <= '0;
            buf_instr_reg <= NOP_INSTR;
            buf_pc_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            pend_reg      <= pend_next;
            buf_instr_reg <= buf_instr_next;
            buf_pc_reg    <= buf_pc_next;
        end
    end

    assign d_instr = load_buf ? buf_instr_reg : bus.IMEM_RDATA;
    assign d_pc    = load_buf ? buf_pc_reg    : pc_reg;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (CLK),
        .rst      (RESET),
        .load     (load_fetch || load_buf),
        .bubble   (bubble),
        .d_instr  (d_instr),
        .d_pc     (d_pc),
        .instr    (bus.INSTR_OUT),
        .pc       (bus.PC_OUT),
        .pc_plus4 (bus.PC_INCREMENT4_OUT),
        .valid    (bus.VALID_OUT)
    );

    assign bus.IMEM_READ = imem_read;
    assign bus.IMEM_ADDR = pc_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus a reset-during-drain sequence.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic CLK;
    logic RESET;
    int   checks;
    int   failures;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0100),
        .NOP_INSTR (NOP)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign bus.IMEM_RDATA = instr_of(bus.IMEM_ADDR);

    typedef struct {
        logic        st;
        logic        bw;
        logic        bt;
        logic [31:0] tgt;
        logic        ibw;
        logic        rd;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic rd, input logic [31:0] addr,
                               input logic v, input logic [31:0] pc);
        chk({tag, ".imem_read"}, {31'd0, bus.IMEM_READ}, {31'd0, rd});
        if (rd) chk({tag, ".imem_addr"}, bus.IMEM_ADDR, addr);
        chk({tag, ".valid"}, {31'd0, bus.VALID_OUT}, {31'd0, v});
        chk({tag, ".instr"}, bus.INSTR_OUT, v ? instr_of(pc) : NOP);
        if (v) begin
            chk({tag, ".pc"}, bus.PC_OUT, pc);
            chk({tag, ".pc4"}, bus.PC_INCREMENT4_OUT, pc + 32'd4);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".imem_read"}, {31'd0, bus.IMEM_READ}, 32'd0);
        chk({tag, ".instr"}, bus.INSTR_OUT, NOP);
        chk({tag, ".valid"}, {31'd0, bus.VALID_OUT}, 32'd0);
        chk({tag, ".pc"}, bus.PC_OUT, 32'd0);
        chk({tag, ".pc4"}, bus.PC_INCREMENT4_OUT, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //           st  bw  bt  tgt            ibw   rd  addr           v   pc
        vecs[0]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0, 1'b1,32'h0000_0100,1'b0,32'h0};
        vecs[1]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1, 1'b1,32'h0000_0104,1'b1,32'h0000_0100};
        vecs[2]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1, 1'b1,32'h0000_0104,1'b0,32'h0};
        vecs[3]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1, 1'b1,32'h0000_0104,1'b0,32'h0};
        vecs[4]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0, 1'b1,32'h0000_0104,1'b0,32'h0};
        vecs[5]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0, 1'b1,32'h0000_0108,1'b1,32'h0000_0104};
        vecs[6]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0, 1'b0,32'h0,        1'b1,32'h0000_0104};
        vecs[7]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0, 1'b0,32'h0,        1'b1,32'h0000_0104};
        vecs[8]  = '{1'b0,1'b0,1'b1,32'h0000_0200,1'b1, 1'b1,32'h0000_010C,1'b1,32'h0000_0108};
        vecs[9]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1, 1'b1,32'h0000_010C,1'b0,32'h0};
        vecs[10] = '{1'b0,1'b0,1'b0,32'h0,        1'b0, 1'b1,32'h0000_010C,1'b0,32'h0};
        vecs[11] = '{1'b0,1'b0,1'b0,32'h0,        1'b0, 1'b1,32'h0000_0200,1'b0,32'h0};
        vecs[12] = '{1'b1,1'b0,1'b1,32'h0000_0300,1'b0, 1'b1,32'h0000_0204,1'b1,32'h0000_0200};
        vecs[13] = '{1'b0,1'b1,1'b1,32'h0000_0400,1'b0, 1'b1,32'h0000_0300,1'b0,32'h0};
        vecs[14] = '{1'b0,1'b0,1'b0,32'h0,        1'b0, 1'b0,32'h0,        1'b0,32'h0};
        vecs[15] = '{1'b0,1'b0,1'b1,32'hFFFF_FFFF,1'b0, 1'b1,32'h0000_0304,1'b1,32'h0000_0300};
        vecs[16] = '{1'b0,1'b0,1'b0,32'h0,        1'b0, 1'b1,32'hFFFF_FFFC,1'b0,32'h0};
        vecs[17] = '{1'b0,1'b0,1'b0,32'h0,        1'b0, 1'b1,32'h0000_0000,1'b1,32'hFFFF_FFFC};
        vecs[18] = '{1'b0,1'b0,1'b1,32'h0000_0600,1'b1, 1'b1,32'h0000_0004,1'b1,32'h0000_0000};
        vecs[19] = '{1'b0,1'b0,1'b1,32'h0000_0700,1'b1, 1'b1,32'h0000_0004,1'b0,32'h0};
        vecs[20] = '{1'b0,1'b0,1'b0,32'h0,        1'b0, 1'b1,32'h0000_0004,1'b0,32'h0};
        vecs[21] = '{1'b0,1'b0,1'b0,32'h0,        1'b0, 1'b1,32'h0000_0700,1'b0,32'h0};

        RESET              = 1'b1;
        bus.STALL          = 1'b0;
        bus.BUSY_WAIT      = 1'b0;
        bus.BRANCH_TAKEN   = 1'b0;
        bus.BRANCH_TARGET  = 32'h0;
        bus.IMEM_BUSY_WAIT = 1'b0;

        repeat (3) @(negedge CLK);
        chk_reset_state("reset");
        $display("reset held: imem_read=%0b valid=%0b instr=%h", bus.IMEM_READ, bus.VALID_OUT, bus.INSTR_OUT);
        RESET = 1'b0;

        for (int i = 0; i < 22; i++) begin
            bus.STALL          = vecs[i].st;
            bus.BUSY_WAIT      = vecs[i].bw;
            bus.BRANCH_TAKEN   = vecs[i].bt;
            bus.BRANCH_TARGET  = vecs[i].tgt;
            bus.IMEM_BUSY_WAIT = vecs[i].ibw;
            #1;
            $display("vec %0d: read=%0b addr=%h valid=%0b instr=%h pc=%h pc4=%h", i, bus.IMEM_READ,
                     bus.IMEM_ADDR, bus.VALID_OUT, bus.INSTR_OUT, bus.PC_OUT, bus.PC_INCREMENT4_OUT);
            chk_outputs($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].v, vecs[i].pc);
            @(negedge CLK);
        end

        // Redirect while imem is busy, then reset in the middle of the drain.
        bus.BRANCH_TAKEN   = 1'b1;
        bus.BRANCH_TARGET  = 32'h0000_0500;
        bus.IMEM_BUSY_WAIT = 1'b1;
        #1;
        $display("seq enter drain: addr=%h valid=%0b pc=%h", bus.IMEM_ADDR, bus.VALID_OUT, bus.PC_OUT);
        chk_outputs("seq_pre", 1'b1, 32'h0000_0704, 1'b1, 32'h0000_0700);
        @(negedge CLK);
        bus.BRANCH_TAKEN = 1'b0;
        #1;
        $display("seq draining: read=%0b addr=%h valid=%0b", bus.IMEM_READ, bus.IMEM_ADDR, bus.VALID_OUT);
        chk_outputs("seq_drain", 1'b1, 32'h0000_0704, 1'b0, 32'h0);
        #2;
        RESET = 1'b1;
        #1;
        $display("seq reset mid-drain: read=%0b valid=%0b instr=%h", bus.IMEM_READ, bus.VALID_OUT, bus.INSTR_OUT);
        chk_reset_state("seq_rst");
        @(negedge CLK);
        bus.IMEM_BUSY_WAIT = 1'b0;
        RESET              = 1'b0;
        #1;
        $display("seq restart: read=%0b addr=%h valid=%0b", bus.IMEM_READ, bus.IMEM_ADDR, bus.VALID_OUT);
        chk_outputs("seq_restart", 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        @(negedge CLK);
        #1;
        $display("seq first instr: addr=%h valid=%0b instr=%h pc=%h", bus.IMEM_ADDR, bus.VALID_OUT,
                 bus.INSTR_OUT, bus.PC_OUT);
        chk_outputs("seq_first", 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
